// File: rtl/sm4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sm4_pkg
// Brief    : SM4 key-schedule types, constants, S-box and round helpers.
// Revision : 1.0
// ============================================================================
package sm4_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int           RK_CNT = 32;
    localparam logic [127:0] FK     = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    localparam logic [7:0] SM4_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [7:0] sm4_sbox_f(input logic [7:0] x);
        return SM4_SBOX[x];
    endfunction

    function automatic word_t sbox_32b(input word_t x);
        return {sm4_sbox_f(x[31:24]), sm4_sbox_f(x[23:16]), sm4_sbox_f(x[15:8]), sm4_sbox_f(x[7:0])};
    endfunction

    function automatic word_t rotl_f(input word_t x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Key-schedule linear transform L'
    function automatic word_t lkey_f(input word_t b);
        return b ^ rotl_f(b, 13) ^ rotl_f(b, 23);
    endfunction

    // Data-path linear transform L, shared with the round datapath
    function automatic word_t lenc_f(input word_t b);
        return b ^ rotl_f(b, 2) ^ rotl_f(b, 10) ^ rotl_f(b, 18) ^ rotl_f(b, 24);
    endfunction

    // CK byte j of round i is (4i+j)*7 mod 256, most significant byte first
    function automatic word_t ck_f(input logic [4:0] round);
        word_t ck;
        ck = '0;
        for (int j = 0; j < 4; j++) begin
            ck[31-8*j -: 8] = 8'((4 * int'(round) + j) * 7);
        end
        return ck;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm4_key_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : sm4_key_sched_if
// Brief    : Key-load, round-key stream and store read port bundle.
// Revision : 1.0
// ============================================================================
interface sm4_key_sched_if #(
    parameter int RPC = 1
);
    logic [127:0]      MK_i;
    logic              MK_VALID_i;
    logic              MK_READY_o;
    logic [32*RPC-1:0] RK_o;
    logic [4:0]        RK_IDX_o;
    logic              RK_VALID_o;
    logic              KEYS_VALID_o;
    logic [4:0]        RD_IDX_i;
    logic              RD_DEC_i;
    logic [31:0]       RD_RK_o;

    modport master (
        output MK_i, MK_VALID_i, RD_IDX_i, RD_DEC_i,
        input  MK_READY_o, RK_o, RK_IDX_o, RK_VALID_o, KEYS_VALID_o, RD_RK_o
    );

    modport slave (
        input  MK_i, MK_VALID_i, RD_IDX_i, RD_DEC_i,
        output MK_READY_o, RK_o, RK_IDX_o, RK_VALID_o, KEYS_VALID_o, RD_RK_o
    );
endinterface
`default_nettype wire

// File: rtl/sm4_key_round.sv
`default_nettype none
// ============================================================================
// Module   : sm4_key_round
// Brief    : One combinational SM4 key round, K4 = K0 ^ L'(S(K1^K2^K3^CK)).
// Revision : 1.0
// ============================================================================
module sm4_key_round
    import sm4_pkg::*;
(
    input  word_t i_k0,
    input  word_t i_k1,
    input  word_t i_k2,
    input  word_t i_k3,
    input  word_t i_ck,
    output word_t o_k4
);
    word_t w_sub;

    assign w_sub = sbox_32b(i_k1 ^ i_k2 ^ i_k3 ^ i_ck);
    assign o_k4  = i_k0 ^ lkey_f(w_sub);
endmodule
`default_nettype wire

// File: rtl/sm4_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : sm4_key_sched
// Brief    : Iterative SM4 key expansion, RPC rounds/clock, optional 32-entry store.
// Revision : 1.0
// ============================================================================
module sm4_key_sched
    import sm4_pkg::*;
#(
    parameter int RPC       = 1,
    parameter int KEY_STORE = 1
) (
    input  logic           CLK_i,
    input  logic           RST_i,
    sm4_key_sched_if.slave bus
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_ready;
    logic              w_accept;
    logic              w_last;
    logic [5:0]        r_cnt;
    word_t             r_k [4];
    word_t             w_kc [RPC+4];
    logic [32*RPC-1:0] w_rk_nxt;
    logic [32*RPC-1:0] r_rk;
    logic [4:0]        r_rk_idx;
    logic              r_rk_valid;
    logic              r_keys_valid;

    assign w_ready  = (r_state != ST_EXPAND);
    assign w_accept = bus.MK_VALID_i & w_ready;
    assign w_last   = (r_cnt == 6'(RK_CNT - RPC));

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE,
            ST_DONE:   if (w_accept) w_state_nxt = ST_EXPAND;
            ST_EXPAND: if (w_last)   w_state_nxt = ST_DONE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Rounds cnt..cnt+RPC-1 chained combinationally; w_kc[i+4] is rk(cnt+i)
    generate
        for (genvar g = 0; g < 4; g++) begin : g_seed
            assign w_kc[g] = r_k[g];
        end
        for (genvar g = 0; g < RPC; g++) begin : g_round
            word_t w_ck;
            assign w_ck = ck_f(r_cnt[4:0] + 5'(g));
            sm4_key_round u_round (
                .i_k0 (w_kc[g]),
                .i_k1 (w_kc[g+1]),
                .i_k2 (w_kc[g+2]),
                .i_k3 (w_kc[g+3]),
                .i_ck (w_ck),
                .o_k4 (w_kc[g+4])
            );
            assign w_rk_nxt[32*g +: 32] = w_kc[g+4];
        end
    endgenerate

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            for (int i = 0; i < 4; i++) r_k[i] <= '0;
            r_cnt        <= '0;
            r_rk         <= '0;
            r_rk_idx     <= '0;
            r_rk_valid   <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_rk_valid <= 1'b0;
            if (w_accept) begin
                for (int i = 0; i < 4; i++) begin
                    r_k[i] <= bus.MK_i[127-32*i -: 32] ^ FK[127-32*i -: 32];
                end
                r_cnt        <= '0;
                r_keys_valid <= 1'b0;
            end else if (r_state == ST_EXPAND) begin
                for (int i = 0; i < 4; i++) r_k[i] <= w_kc[RPC+i];
                r_cnt      <= r_cnt + 6'(RPC);
                r_rk       <= w_rk_nxt;
                r_rk_idx   <= r_cnt[4:0];
                r_rk_valid <= 1'b1;
                if (w_last) r_keys_valid <= 1'b1;
            end
        end
    end

    generate
        if (KEY_STORE != 0) begin : g_store
            word_t       r_mem [RK_CNT];
            logic [4:0]  w_rd_addr;
            logic [31:0] r_rd_rk;

            assign w_rd_addr = bus.RD_DEC_i ? (5'd31 - bus.RD_IDX_i) : bus.RD_IDX_i;

            // Contents survive reset; KEYS_VALID_o qualifies them
            always_ff @(posedge CLK_i) begin
                if (r_state == ST_EXPAND) begin
                    for (int i = 0; i < RPC; i++) begin
                        r_mem[r_cnt[4:0] + 5'(i)] <= w_kc[i+4];
                    end
                end
            end

            always_ff @(posedge CLK_i or posedge RST_i) begin
                if (RST_i) begin
                    r_rd_rk <= '0;
                end else begin
                    r_rd_rk <= r_mem[w_rd_addr];
                end
            end

            assign bus.RD_RK_o = r_rd_rk;
        end else begin : g_no_store
            assign bus.RD_RK_o = '0;
        end
    endgenerate

    assign bus.MK_READY_o   = w_ready;
    assign bus.RK_o         = r_rk;
    assign bus.RK_IDX_o     = r_rk_idx;
    assign bus.RK_VALID_o   = r_rk_valid;
    assign bus.KEYS_VALID_o = r_keys_valid;
endmodule
`default_nettype wire
